capi_command_arbiter: RTL and testbench

- Shares the single PSL command interface among NUM_REQ work-element requesters, e.g. request-block read, stripe reads and parity write.
- Each requester is assigned the fixed tag equal to its index. The block tracks PSL command credits and allows at most one outstanding command per requester.
- Responses are routed back to the owning requester by tag.
- Sits between the work element's sequencing FSM and the PSL command/response ports.

---
 rtl/capi_command_arbiter.sv | 189 ++++++++++++++++++
 tb/tb_capi_command_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capi_command_arbiter.sv
// capi_command_arbiter
//   Shares one PSL command interface among NUM_REQ work-element requesters.
//   Requester i always issues with tag i and may have at most one command in
//   flight. PSL command credits are loaded from croom once per job and
//   tracked with signed returns from the response port.
//
// Ports
//   clock, reset        system clock, synchronous active-high reset
//   enable              job running; gates grants and the credit load
//   croom               initial PSL command credit count
//   req_valid/command/address/size  per-requester command request (flattened)
//   req_ready           one-hot combinational grant strobe
//   rsp_done, rsp_code  one-cycle completion pulse routed by tag, with code
//   cmd_*               registered PSL command port with odd parity
//   resp_valid/tag/code/credits     PSL response port
//   tag_error           sticky flag for a response with an unexpected tag
module capi_command_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int CREDIT_W = 9
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [7:0]            croom,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*13-1:0] req_command,
  input  logic [NUM_REQ*64-1:0] req_address,
  input  logic [NUM_REQ*12-1:0] req_size,
  output logic [NUM_REQ-1:0]    req_ready,
  output logic [NUM_REQ-1:0]    rsp_done,
  output logic [7:0]            rsp_code,
  output logic                  cmd_valid,
  output logic [12:0]           cmd_command,
  output logic [63:0]           cmd_address,
  output logic [11:0]           cmd_size,
  output logic [7:0]            cmd_tag,
  output logic                  cmd_command_parity,
  output logic                  cmd_address_parity,
  output logic                  cmd_tag_parity,
  input  logic                  resp_valid,
  input  logic [7:0]            resp_tag,
  input  logic [7:0]            resp_code,
  input  logic [8:0]            resp_credits,
  output logic                  tag_error
);

  localparam int IDX_W   = $clog2(NUM_REQ);
  localparam int PAD_N   = 1 << IDX_W;
  localparam logic signed [CREDIT_W-1:0] CREDITS_ZERO = '0;

  logic signed [CREDIT_W-1:0] credits_reg;
  logic                       loaded_reg;
  logic [NUM_REQ-1:0]         busy_reg;
  logic [IDX_W-1:0]           rr_ptr_reg;
  logic                       cmd_valid_reg;
  logic [12:0]                cmd_command_reg;
  logic [63:0]                cmd_address_reg;
  logic [11:0]                cmd_size_reg;
  logic [7:0]                 cmd_tag_reg;
  logic [NUM_REQ-1:0]         rsp_done_reg;
  logic [7:0]                 rsp_code_reg;
  logic                       tag_error_reg;

  logic [12:0] command_arr [NUM_REQ];
  logic [63:0] address_arr [NUM_REQ];
  logic [11:0] size_arr    [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic [PAD_N-1:0]   eligible_pad;
  logic [PAD_N-1:0]   busy_pad;
  logic [IDX_W:0]     rr_sum;
  logic [IDX_W-1:0]   rr_idx;
  logic [IDX_W-1:0]   grant_idx;
  logic               grant_hit;
  logic               grant_fire;
  logic               resp_in_range;
  logic               resp_hit;
  logic [NUM_REQ-1:0] resp_clear;

  logic signed [CREDIT_W-1:0] credit_ret;
  logic signed [CREDIT_W-1:0] grant_dec;
  logic signed [CREDIT_W-1:0] credits_next;

  // A requester whose completion is being reported this cycle sits out one
  // more cycle, so a re-grant never lands in the same cycle as its rsp_done.
  assign eligible = req_valid & ~busy_reg & ~rsp_done_reg;

  always_comb begin
    eligible_pad = '0;
    eligible_pad[NUM_REQ-1:0] = eligible;
    busy_pad = '0;
    busy_pad[NUM_REQ-1:0] = busy_reg;
  end

  // Round-robin search: first eligible index at or after rr_ptr, wrapping.
  always_comb begin
    grant_idx = '0;
    grant_hit = 1'b0;
    rr_sum    = '0;
    rr_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(k);
      if (rr_sum >= (IDX_W+1)'(NUM_REQ)) begin
        rr_sum = rr_sum - (IDX_W+1)'(NUM_REQ);
      end
      rr_idx = rr_sum[IDX_W-1:0];
      if (!grant_hit && eligible_pad[rr_idx]) begin
        grant_hit = 1'b1;
        grant_idx = rr_idx;
      end
    end
  end

  // Reset is folded in so no strobe escapes during the reset cycle itself.
  assign grant_fire = !reset && enable && loaded_reg &&
                      (credits_reg > CREDITS_ZERO) && grant_hit;

  assign resp_in_range = resp_tag < 8'(NUM_REQ);
  assign resp_hit      = resp_valid && resp_in_range &&
                         busy_pad[resp_tag[IDX_W-1:0]];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign command_arr[gi] = req_command[gi*13 +: 13];
    assign address_arr[gi] = req_address[gi*64 +: 64];
    assign size_arr[gi]    = req_size[gi*12 +: 12];
    assign req_ready[gi]   = grant_fire && (grant_idx == IDX_W'(gi));
    assign resp_clear[gi]  = resp_hit && (resp_tag == 8'(gi));
  end

  // Returned credits are signed, so they are sign-extended into the counter.
  assign credit_ret   = resp_valid ? CREDIT_W'($signed(resp_credits)) : CREDITS_ZERO;
  assign grant_dec    = grant_fire ? CREDIT_W'(1) : CREDITS_ZERO;
  assign credits_next = credits_reg - grant_dec + credit_ret;

  always_ff @(posedge clock) begin
    if (reset) begin
      credits_reg     <= '0;
      loaded_reg      <= 1'b0;
      busy_reg        <= '0;
      rr_ptr_reg      <= '0;
      cmd_valid_reg   <= 1'b0;
      cmd_command_reg <= '0;
      cmd_address_reg <= '0;
      cmd_size_reg    <= '0;
      cmd_tag_reg     <= '0;
      rsp_done_reg    <= '0;
      rsp_code_reg    <= '0;
      tag_error_reg   <= 1'b0;
    end else begin
      if (enable && !loaded_reg) begin
        credits_reg <= CREDIT_W'(croom);
        loaded_reg  <= 1'b1;
      end else begin
        credits_reg <= credits_next;
      end

      busy_reg      <= (busy_reg | req_ready) & ~resp_clear;
      cmd_valid_reg <= grant_fire;
      if (grant_fire) begin
        cmd_command_reg <= command_arr[grant_idx];
        cmd_address_reg <= address_arr[grant_idx];
        cmd_size_reg    <= size_arr[grant_idx];
        cmd_tag_reg     <= 8'(grant_idx);
        rr_ptr_reg      <= (grant_idx == IDX_W'(NUM_REQ-1)) ? '0 : grant_idx + 1'b1;
      end

      rsp_done_reg <= resp_clear;
      if (resp_hit) begin
        rsp_code_reg <= resp_code;
      end
      if (resp_valid && !resp_hit) begin
        tag_error_reg <= 1'b1;
      end
    end
  end

  assign cmd_valid          = cmd_valid_reg;
  assign cmd_command        = cmd_command_reg;
  assign cmd_address        = cmd_address_reg;
  assign cmd_size           = cmd_size_reg;
  assign cmd_tag            = cmd_tag_reg;
  assign cmd_command_parity = ~^cmd_command_reg;
  assign cmd_address_parity = ~^cmd_address_reg;
  assign cmd_tag_parity     = ~^cmd_tag_reg;
  assign rsp_done           = rsp_done_reg;
  assign rsp_code           = rsp_code_reg;
  assign tag_error          = tag_error_reg;

endmodule

// File: tb/tb_capi_command_arbiter.sv
// Testbench for capi_command_arbiter: directed scenarios plus a randomized
// run, all checked against a transaction-level model of the arbiter.
module tb_capi_command_arbiter;

  localparam int N = 4;

  logic            clock = 1'b0;
  logic            reset;
  logic            enable;
  logic [7:0]      croom;
  logic [N-1:0]    req_valid;
  logic [N*13-1:0] req_command;
  logic [N*64-1:0] req_address;
  logic [N*12-1:0] req_size;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_done;
  logic [7:0]      rsp_code;
  logic            cmd_valid;
  logic [12:0]     cmd_command;
  logic [63:0]     cmd_address;
  logic [11:0]     cmd_size;
  logic [7:0]      cmd_tag;
  logic            cmd_command_parity;
  logic            cmd_address_parity;
  logic            cmd_tag_parity;
  logic            resp_valid;
  logic [7:0]      resp_tag;
  logic [7:0]      resp_code;
  logic [8:0]      resp_credits;
  logic            tag_error;

  int n_checks = 0;
  int n_fail   = 0;

  capi_command_arbiter #(.NUM_REQ(N), .CREDIT_W(9)) dut (
    .clock(clock), .reset(reset), .enable(enable), .croom(croom),
    .req_valid(req_valid), .req_command(req_command),
    .req_address(req_address), .req_size(req_size), .req_ready(req_ready),
    .rsp_done(rsp_done), .rsp_code(rsp_code), .cmd_valid(cmd_valid),
    .cmd_command(cmd_command), .cmd_address(cmd_address), .cmd_size(cmd_size),
    .cmd_tag(cmd_tag), .cmd_command_parity(cmd_command_parity),
    .cmd_address_parity(cmd_address_parity), .cmd_tag_parity(cmd_tag_parity),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_code(resp_code),
    .resp_credits(resp_credits), .tag_error(tag_error)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  int          m_credits;
  bit          m_loaded;
  int          m_rr;
  bit [N-1:0]  m_busy;
  bit [N-1:0]  m_rsp_done;
  bit [7:0]    m_rsp_code;
  bit          m_tag_error;
  bit          m_cmd_valid;
  bit [12:0]   m_cmd_command;
  bit [63:0]   m_cmd_address;
  bit [11:0]   m_cmd_size;
  bit [7:0]    m_cmd_tag;

  // Which requester the arbiter should accept with the current inputs.
  function automatic int exp_grant();
    if (reset || !enable || !m_loaded || m_credits <= 0) return -1;
    for (int k = 0; k < N; k++) begin
      int i = (m_rr + k) % N;
      if (req_valid[i] && !m_busy[i] && !m_rsp_done[i]) return i;
    end
    return -1;
  endfunction

  function automatic bit [N-1:0] exp_ready();
    bit [N-1:0] r = '0;
    int g = exp_grant();
    if (g >= 0) r[g] = 1'b1;
    return r;
  endfunction

  // Advance the model across one clock edge, then wait for that edge.
  task automatic tick();
    int g = exp_grant();
    int t = int'(resp_tag);
    if (reset) begin
      m_credits = 0; m_loaded = 0; m_rr = 0; m_busy = '0; m_rsp_done = '0;
      m_rsp_code = '0; m_tag_error = 0; m_cmd_valid = 0; m_cmd_command = '0;
      m_cmd_address = '0; m_cmd_size = '0; m_cmd_tag = '0;
    end else begin
      if (enable && !m_loaded) begin
        m_credits = int'(croom);
        m_loaded  = 1;
      end else begin
        m_credits = m_credits - ((g >= 0) ? 1 : 0) +
                    (resp_valid ? int'($signed(resp_credits)) : 0);
      end
      m_rsp_done = '0;
      if (resp_valid) begin
        if (t < N && m_busy[t]) begin
          m_rsp_done[t] = 1'b1;
          m_rsp_code    = resp_code;
          m_busy[t]     = 1'b0;
        end else begin
          m_tag_error = 1'b1;
        end
      end
      m_cmd_valid = (g >= 0);
      if (g >= 0) begin
        m_cmd_command = req_command[g*13 +: 13];
        m_cmd_address = req_address[g*64 +: 64];
        m_cmd_size    = req_size[g*12 +: 12];
        m_cmd_tag     = 8'(g);
        m_busy[g]     = 1'b1;
        m_rr          = (g + 1) % N;
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic clear_resp();
    resp_valid = 0; resp_tag = '0; resp_code = '0; resp_credits = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; enable = 0; croom = '0; req_valid = '0;
    req_command = '0; req_address = '0; req_size = '0;
    clear_resp();
    tick(); tick();
    #1;
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cmd_valid: got %b want 0", cmd_valid); end
    n_checks++; if (cmd_tag !== 8'd0) begin n_fail++; $display("FAIL reset_cmd_tag: got %0d want 0", cmd_tag); end
    n_checks++; if (cmd_address !== 64'd0) begin n_fail++; $display("FAIL reset_cmd_address: got %h want 0", cmd_address); end
    n_checks++; if (cmd_command !== 13'd0 || cmd_size !== 12'd0) begin n_fail++; $display("FAIL reset_cmd_fields: got %h/%h want 0/0", cmd_command, cmd_size); end
    n_checks++; if (rsp_done !== 4'b0000 || rsp_code !== 8'd0) begin n_fail++; $display("FAIL reset_rsp: got %b/%h want 0000/00", rsp_done, rsp_code); end
    n_checks++; if (tag_error !== 1'b0) begin n_fail++; $display("FAIL reset_tag_error: got %b want 0", tag_error); end
    n_checks++; if (cmd_tag_parity !== 1'b1) begin n_fail++; $display("FAIL reset_tag_parity: got %b want 1", cmd_tag_parity); end
    n_checks++; if (int'(dut.credits_reg) !== 0) begin n_fail++; $display("FAIL reset_credits: got %0d want 0", dut.credits_reg); end
    $display("reset: outputs checked after reset");
  endtask

  task automatic test_first_grant();
    reset = 0; enable = 1; croom = 8'd8; req_valid = 4'b0001;
    req_command[12:0] = 13'h0A00; req_address[63:0] = 64'h1000; req_size[11:0] = 12'd128;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL load_cycle_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL first_ready: got %b want 0001", req_ready); end
    n_checks++; if (int'(dut.credits_reg) !== 8) begin n_fail++; $display("FAIL loaded_credits: got %0d want 8", dut.credits_reg); end
    tick();
    n_checks++; if (cmd_valid !== 1'b1 || cmd_tag !== 8'd0) begin n_fail++; $display("FAIL first_cmd: got valid=%b tag=%0d want 1/0", cmd_valid, cmd_tag); end
    n_checks++; if (cmd_address !== 64'h1000 || cmd_size !== 12'd128 || cmd_command !== 13'h0A00) begin n_fail++; $display("FAIL first_payload: got %h/%0d/%h want 1000/128/0a00", cmd_address, cmd_size, cmd_command); end
    n_checks++; if ({cmd_command_parity, cmd_address_parity, cmd_tag_parity} !== 3'b101) begin n_fail++; $display("FAIL first_parity: got %b want 101", {cmd_command_parity, cmd_address_parity, cmd_tag_parity}); end
    n_checks++; if (int'(dut.credits_reg) !== 7) begin n_fail++; $display("FAIL first_credits: got %0d want 7", dut.credits_reg); end
    req_valid = '0;
    resp_valid = 1; resp_tag = 8'd0; resp_code = 8'h3C; resp_credits = 9'd1;
    tick();
    clear_resp();
    n_checks++; if (rsp_done !== 4'b0001 || rsp_code !== 8'h3C) begin n_fail++; $display("FAIL first_rsp: got %b/%h want 0001/3c", rsp_done, rsp_code); end
    n_checks++; if (cmd_valid !== 1'b0) begin n_fail++; $display("FAIL first_cmd_drop: got %b want 0", cmd_valid); end
    tick();
    n_checks++; if (rsp_done !== 4'b0000) begin n_fail++; $display("FAIL first_rsp_pulse: got %b want 0000", rsp_done); end
    $display("first_grant: tag 0 issued and completed");
  endtask

  task automatic test_round_robin();
    int exp_idx = 1;
    int prev = -1;
    for (int i = 0; i < N; i++) begin
      req_address[i*64 +: 64] = 64'h2000 + 64'(i * 'h80);
      req_command[i*13 +: 13] = 13'h0A00;
      req_size[i*12 +: 12]    = 12'd128;
    end
    req_valid = 4'b1111;
    for (int c = 0; c < 12; c++) begin
      resp_valid = cmd_valid; resp_tag = cmd_tag; resp_code = 8'h00; resp_credits = 9'd1;
      #1;
      n_checks++; if (req_ready !== (4'b0001 << exp_idx)) begin n_fail++; $display("FAIL rr_order: cycle %0d got %b want %b", c, req_ready, 4'b0001 << exp_idx); end
      if (prev >= 0) begin
        n_checks++; if (cmd_valid !== 1'b1 || cmd_tag !== 8'(prev) || cmd_address !== 64'h2000 + 64'(prev * 'h80)) begin n_fail++; $display("FAIL rr_cmd: cycle %0d got %b/%0d/%h want 1/%0d", c, cmd_valid, cmd_tag, cmd_address, prev); end
      end
      $display("round_robin: cycle %0d ready=%b", c, req_ready);
      tick();
      prev = exp_idx;
      exp_idx = (exp_idx + 1) % N;
    end
    req_valid = '0;
    for (int c = 0; c < 4; c++) begin
      resp_valid = cmd_valid; resp_tag = cmd_tag; resp_credits = 9'd1;
      tick();
    end
    clear_resp();
    tick();
  endtask

  task automatic test_credit_stall();
    reset = 1; tick(); reset = 0;
    croom = 8'd1; enable = 1; req_valid = 4'b0011;
    tick();
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL stall_first: got %b want 0001", req_ready); end
    tick();
    n_checks++; if (cmd_valid !== 1'b1 || cmd_tag !== 8'd0) begin n_fail++; $display("FAIL stall_cmd0: got %b/%0d want 1/0", cmd_valid, cmd_tag); end
    for (int c = 0; c < 4; c++) begin
      n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL stall_blocked: cycle %0d got %b want 0000", c, req_ready); end
      if (c < 3) tick();
    end
    resp_valid = 1; resp_tag = 8'd0; resp_code = 8'h01; resp_credits = 9'd1;
    tick();
    clear_resp();
    n_checks++; if (rsp_done !== 4'b0001) begin n_fail++; $display("FAIL stall_rsp: got %b want 0001", rsp_done); end
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL stall_release: got %b want 0010", req_ready); end
    tick();
    n_checks++; if (cmd_valid !== 1'b1 || cmd_tag !== 8'd1) begin n_fail++; $display("FAIL stall_cmd1: got %b/%0d want 1/1", cmd_valid, cmd_tag); end
    req_valid = '0;
    resp_valid = 1; resp_tag = 8'd1; resp_credits = 9'd1;
    tick();
    clear_resp();
    tick();
    $display("credit_stall: single credit serialised two requesters");
  endtask

  task automatic test_simultaneous();
    reset = 1; tick(); reset = 0;
    croom = 8'd4; enable = 1; req_valid = 4'b0010;
    tick();
    #1;
    n_checks++; if (req_ready !== 4'b0010) begin n_fail++; $display("FAIL simul_first: got %b want 0010", req_ready); end
    tick();
    n_checks++; if (int'(dut.credits_reg) !== 3) begin n_fail++; $display("FAIL simul_before: got %0d want 3", dut.credits_reg); end
    req_valid = 4'b0001;
    resp_valid = 1; resp_tag = 8'd1; resp_code = 8'h22; resp_credits = 9'd2;
    #1;
    n_checks++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL simul_grant: got %b want 0001", req_ready); end
    tick();
    clear_resp();
    req_valid = '0;
    n_checks++; if (int'(dut.credits_reg) !== 4) begin n_fail++; $display("FAIL simul_credits: got %0d want 4", dut.credits_reg); end
    n_checks++; if (rsp_done !== 4'b0010 || cmd_valid !== 1'b1 || cmd_tag !== 8'd0) begin n_fail++; $display("FAIL simul_outputs: got %b/%b/%0d want 0010/1/0", rsp_done, cmd_valid, cmd_tag); end
    resp_valid = 1; resp_tag = 8'd0; resp_credits = 9'd1;
    tick();
    clear_resp();
    tick();
    $display("simultaneous: grant and credit return in one cycle");
  endtask

  task automatic test_tag_error();
    n_checks++; if (tag_error !== 1'b0) begin n_fail++; $display("FAIL tagerr_initial: got %b want 0", tag_error); end
    resp_valid = 1; resp_tag = 8'd2; resp_credits = 9'd0;
    tick();
    clear_resp();
    n_checks++; if (tag_error !== 1'b1 || rsp_done !== 4'b0000) begin n_fail++; $display("FAIL tagerr_idle: got %b/%b want 1/0000", tag_error, rsp_done); end
    reset = 1; tick(); reset = 0;
    n_checks++; if (tag_error !== 1'b0) begin n_fail++; $display("FAIL tagerr_reset: got %b want 0", tag_error); end
    resp_valid = 1; resp_tag = 8'd5; resp_credits = 9'd0;
    tick();
    clear_resp();
    for (int c = 0; c < 3; c++) begin
      n_checks++; if (tag_error !== 1'b1 || rsp_done !== 4'b0000) begin n_fail++; $display("FAIL tagerr_sticky: cycle %0d got %b/%b want 1/0000", c, tag_error, rsp_done); end
      tick();
    end
    $display("tag_error: idle tag and out-of-range tag flagged");
  endtask

  task automatic test_reset_mid();
    reset = 1; tick(); reset = 0;
    croom = 8'd8; enable = 1; req_valid = 4'b0011;
    tick(); tick(); tick();
    n_checks++; if (cmd_valid !== 1'b1 || cmd_tag !== 8'd1) begin n_fail++; $display("FAIL midreset_setup: got %b/%0d want 1/1", cmd_valid, cmd_tag); end
    reset = 1;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midreset_ready: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (cmd_valid !== 1'b0 || cmd_tag !== 8'd0 || cmd_address !== 64'd0) begin n_fail++; $display("FAIL midreset_cmd: got %b/%0d/%h want 0/0/0", cmd_valid, cmd_tag, cmd_address); end
    n_checks++; if (int'(dut.credits_reg) !== 0 || rsp_done !== 4'b0000 || tag_error !== 1'b0) begin n_fail++; $display("FAIL midreset_state: got %0d/%b/%b want 0/0000/0", dut.credits_reg, rsp_done, tag_error); end
    reset = 0; croom = 8'd5; req_valid = 4'b1111;
    #1;
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL midreset_load: got %b want 0000", req_ready); end
    tick();
    n_checks++; if (int'(dut.credits_reg) !== 5 || req_ready !== 4'b0001) begin n_fail++; $display("FAIL midreset_restart: got %0d/%b want 5/0001", dut.credits_reg, req_ready); end
    tick();
    $display("reset_mid: state forgotten, arbitration restarted at 0");
  endtask

  task automatic test_random();
    int n_grants = 0;
    reset = 1; req_valid = '0; clear_resp(); tick(); reset = 0;
    croom = 8'($urandom_range(1, 6));
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 7) != 0);
      req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) begin
        req_command[i*13 +: 13] = 13'($urandom);
        req_address[i*64 +: 64] = {$urandom, $urandom};
        req_size[i*12 +: 12]    = 12'($urandom);
      end
      clear_resp();
      if ($urandom_range(0, 1) == 1) begin
        int i = int'($urandom_range(0, N - 1));
        if (m_busy[i]) begin
          resp_valid = 1; resp_tag = 8'(i); resp_code = 8'($urandom);
          resp_credits = 9'($urandom_range(0, 2));
        end
      end
      if ($urandom_range(0, 99) == 0) begin
        resp_valid = 1; resp_tag = 8'($urandom_range(N, 255)); resp_credits = 9'd0;
      end
      #1;
      n_checks++; if (req_ready !== exp_ready()) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %b want %b", c, req_ready, exp_ready()); end
      n_checks++; if (cmd_valid !== m_cmd_valid) begin n_fail++; $display("FAIL rand_cmd_valid: cycle %0d got %b want %b", c, cmd_valid, m_cmd_valid); end
      n_checks++; if (cmd_tag !== m_cmd_tag || cmd_command !== m_cmd_command) begin n_fail++; $display("FAIL rand_cmd_tag: cycle %0d got %0d/%h want %0d/%h", c, cmd_tag, cmd_command, m_cmd_tag, m_cmd_command); end
      n_checks++; if (cmd_address !== m_cmd_address || cmd_size !== m_cmd_size) begin n_fail++; $display("FAIL rand_cmd_payload: cycle %0d got %h/%h want %h/%h", c, cmd_address, cmd_size, m_cmd_address, m_cmd_size); end
      n_checks++; if ({cmd_command_parity, cmd_address_parity, cmd_tag_parity} !== {~^m_cmd_command, ~^m_cmd_address, ~^m_cmd_tag}) begin n_fail++; $display("FAIL rand_parity: cycle %0d got %b want %b", c, {cmd_command_parity, cmd_address_parity, cmd_tag_parity}, {~^m_cmd_command, ~^m_cmd_address, ~^m_cmd_tag}); end
      n_checks++; if (rsp_done !== m_rsp_done || rsp_code !== m_rsp_code) begin n_fail++; $display("FAIL rand_rsp: cycle %0d got %b/%h want %b/%h", c, rsp_done, rsp_code, m_rsp_done, m_rsp_code); end
      n_checks++; if (tag_error !== m_tag_error) begin n_fail++; $display("FAIL rand_tag_error: cycle %0d got %b want %b", c, tag_error, m_tag_error); end
      n_checks++; if (int'(dut.credits_reg) !== m_credits) begin n_fail++; $display("FAIL rand_credits: cycle %0d got %0d want %0d", c, dut.credits_reg, m_credits); end
      if (exp_grant() >= 0) n_grants++;
      tick();
    end
    $display("random: 400 cycles, %0d grants", n_grants);
  endtask

  initial begin
    test_reset();
    test_first_grant();
    test_round_robin();
    test_credit_stall();
    test_simultaneous();
    test_tag_error();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
